qsys_st_channel_filter: RTL and testbench

//  Parametrised Avalon-ST channel adapter/filter between a wide-channel source and a narrower sink.

---
 rtl/qsys_st_channel_filter.sv | 183 ++++++++++++++++++
 tb/tb_qsys_st_channel_filter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/qsys_st_channel_filter.sv
// rtl/qsys_st_channel_filter.sv - Avalon-ST channel filter/narrower with registered skid output and drop counter
// Drops beats or whole packets above MAX_CHANNEL; forwarded beats pass through a 2-entry output buffer.
module qsys_st_channel_filter #(
  parameter int DATA_W      = 8,
  parameter int IN_CHAN_W   = 8,
  parameter int OUT_CHAN_W  = 1,
  parameter int MAX_CHANNEL = 0,
  parameter int PKT_DROP    = 1,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  output logic                  in_ready,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     in_data,
  input  logic [IN_CHAN_W-1:0]  in_channel,
  input  logic                  in_startofpacket,
  input  logic                  in_endofpacket,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     out_data,
  output logic [OUT_CHAN_W-1:0] out_channel,
  output logic                  out_startofpacket,
  output logic                  out_endofpacket,
  output logic [CNT_W-1:0]      drop_count,
  input  logic                  drop_clr
);

  generate
    if (MAX_CHANNEL >= (1 << OUT_CHAN_W)) begin : g_bad_max_channel
      $error("MAX_CHANNEL must be below 2**OUT_CHAN_W");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PASS = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  localparam logic [IN_CHAN_W-1:0] MAX_CHAN = IN_CHAN_W'(MAX_CHANNEL);
  localparam logic [CNT_W-1:0]     CNT_SAT  = '1;

  state_t                  state_q, state_d;
  logic                    in_ready_q, in_ready_d;
  logic                    out_valid_q, out_valid_d;
  logic [DATA_W-1:0]       out_data_q, out_data_d;
  logic [OUT_CHAN_W-1:0]   out_chan_q, out_chan_d;
  logic                    out_sop_q, out_sop_d;
  logic                    out_eop_q, out_eop_d;
  logic                    skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0]       skid_data_q, skid_data_d;
  logic [OUT_CHAN_W-1:0]   skid_chan_q, skid_chan_d;
  logic                    skid_sop_q, skid_sop_d;
  logic                    skid_eop_q, skid_eop_d;
  logic [CNT_W-1:0]        drop_cnt_q, drop_cnt_d;

  logic accept;
  logic chan_over;
  logic beat_drop;
  logic beat_fwd;
  logic out_take;

  // Drop decision and packet-mode FSM; only accepted beats move the state.
  always_comb begin
    accept    = in_valid & in_ready_q;
    chan_over = (in_channel > MAX_CHAN);
    beat_drop = chan_over;
    state_d   = state_q;
    if (PKT_DROP != 0) begin
      if (!in_startofpacket) begin
        case (state_q)
          ST_PASS: beat_drop = 1'b0;
          ST_DROP: beat_drop = 1'b1;
          default: beat_drop = chan_over;
        endcase
      end
      if (accept) begin
        if (in_endofpacket) begin
          state_d = ST_IDLE;
        end else if (in_startofpacket) begin
          state_d = chan_over ? ST_DROP : ST_PASS;
        end
      end
    end
    beat_fwd = accept & ~beat_drop;
  end

  // Output register plus skid entry; in_ready is registered from skid occupancy.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_chan_d   = out_chan_q;
    out_sop_d    = out_sop_q;
    out_eop_d    = out_eop_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_chan_d  = skid_chan_q;
    skid_sop_d   = skid_sop_q;
    skid_eop_d   = skid_eop_q;
    out_take     = ~out_valid_q | out_ready;

    if (skid_valid_q) begin
      if (out_ready) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        out_chan_d   = skid_chan_q;
        out_sop_d    = skid_sop_q;
        out_eop_d    = skid_eop_q;
        skid_valid_d = 1'b0;
      end
    end else if (beat_fwd) begin
      if (out_take) begin
        out_valid_d = 1'b1;
        out_data_d  = in_data;
        out_chan_d  = in_channel[OUT_CHAN_W-1:0];
        out_sop_d   = in_startofpacket;
        out_eop_d   = in_endofpacket;
      end else begin
        skid_valid_d = 1'b1;
        skid_data_d  = in_data;
        skid_chan_d  = in_channel[OUT_CHAN_W-1:0];
        skid_sop_d   = in_startofpacket;
        skid_eop_d   = in_endofpacket;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    in_ready_d = ~skid_valid_d;
  end

  // Clear has priority over a same-cycle drop.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop_clr) begin
      drop_cnt_d = '0;
    end else if (accept && beat_drop && (drop_cnt_q != CNT_SAT)) begin
      drop_cnt_d = drop_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      in_ready_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_chan_q   <= '0;
      out_sop_q    <= 1'b0;
      out_eop_q    <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_chan_q  <= '0;
      skid_sop_q   <= 1'b0;
      skid_eop_q   <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_chan_q   <= out_chan_d;
      out_sop_q    <= out_sop_d;
      out_eop_q    <= out_eop_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_chan_q  <= skid_chan_d;
      skid_sop_q   <= skid_sop_d;
      skid_eop_q   <= skid_eop_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  assign in_ready          = in_ready_q;
  assign out_valid         = out_valid_q;
  assign out_data          = out_data_q;
  assign out_channel       = out_chan_q;
  assign out_startofpacket = out_sop_q;
  assign out_endofpacket   = out_eop_q;
  assign drop_count        = drop_cnt_q;

endmodule

// File: tb/tb_qsys_st_channel_filter.sv
// tb/tb_qsys_st_channel_filter.sv - directed bench for qsys_st_channel_filter
// Three instances share inputs: packet-drop mode, per-beat mode, and per-beat with a 2-bit counter.
module tb_qsys_st_channel_filter;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;
  logic [7:0] in_channel = '0;
  logic       in_sop = 1'b0;
  logic       in_eop = 1'b0;
  logic       out_ready = 1'b1;
  logic       drop_clr = 1'b0;

  logic        p_in_ready, p_out_valid, p_out_sop, p_out_eop;
  logic [7:0]  p_out_data;
  logic [0:0]  p_out_chan;
  logic [15:0] p_drop;
  logic        b_in_ready, b_out_valid, b_out_sop, b_out_eop;
  logic [7:0]  b_out_data;
  logic [0:0]  b_out_chan;
  logic [15:0] b_drop;
  logic        s_in_ready, s_out_valid, s_out_sop, s_out_eop;
  logic [7:0]  s_out_data;
  logic [0:0]  s_out_chan;
  logic [1:0]  s_drop;

  int total = 0;
  int bad = 0;
  logic [7:0] cap_q[$];

  always #5 clk = ~clk;

  qsys_st_channel_filter u_pkt (
    .clk(clk), .reset_n(reset_n), .in_ready(p_in_ready), .in_valid(in_valid),
    .in_data(in_data), .in_channel(in_channel), .in_startofpacket(in_sop),
    .in_endofpacket(in_eop), .out_ready(out_ready), .out_valid(p_out_valid),
    .out_data(p_out_data), .out_channel(p_out_chan), .out_startofpacket(p_out_sop),
    .out_endofpacket(p_out_eop), .drop_count(p_drop), .drop_clr(drop_clr)
  );

  qsys_st_channel_filter #(.PKT_DROP(0)) u_beat (
    .clk(clk), .reset_n(reset_n), .in_ready(b_in_ready), .in_valid(in_valid),
    .in_data(in_data), .in_channel(in_channel), .in_startofpacket(in_sop),
    .in_endofpacket(in_eop), .out_ready(out_ready), .out_valid(b_out_valid),
    .out_data(b_out_data), .out_channel(b_out_chan), .out_startofpacket(b_out_sop),
    .out_endofpacket(b_out_eop), .drop_count(b_drop), .drop_clr(drop_clr)
  );

  qsys_st_channel_filter #(.PKT_DROP(0), .CNT_W(2)) u_sat (
    .clk(clk), .reset_n(reset_n), .in_ready(s_in_ready), .in_valid(in_valid),
    .in_data(in_data), .in_channel(in_channel), .in_startofpacket(in_sop),
    .in_endofpacket(in_eop), .out_ready(out_ready), .out_valid(s_out_valid),
    .out_data(s_out_data), .out_channel(s_out_chan), .out_startofpacket(s_out_sop),
    .out_endofpacket(s_out_eop), .drop_count(s_drop), .drop_clr(drop_clr)
  );

  // A beat transfers at the next posedge when valid & ready are seen here.
  always @(negedge clk) begin
    if (reset_n && p_out_valid && out_ready) cap_q.push_back(p_out_data);
  end

  typedef struct packed {
    logic [7:0] data;
    logic [7:0] chan;
    logic       sop;
    logic       eop;
    logic       fwd_pkt;
    logic       fwd_beat;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [7:0] d, logic [7:0] c, logic s, logic e, logic fp, logic fb);
    vec_t v;
    v.data = d; v.chan = c; v.sop = s; v.eop = e; v.fwd_pkt = fp; v.fwd_beat = fb;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] d, input logic [7:0] c, input logic s, input logic e);
    in_valid = 1'b1; in_data = d; in_channel = c; in_sop = s; in_eop = e;
  endtask

  task automatic idle();
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
  endtask

  initial begin
    int exp_p;
    int exp_b;
    int exp_s;

    // Stream vectors; out_ready stays high so every accepted beat shows one cycle later.
    vecs.push_back(mk(8'h11, 8'd0, 1, 0, 1, 1));
    vecs.push_back(mk(8'h12, 8'd0, 0, 0, 1, 1));
    vecs.push_back(mk(8'h13, 8'd0, 0, 0, 1, 1));
    vecs.push_back(mk(8'h14, 8'd0, 0, 1, 1, 1));
    vecs.push_back(mk(8'h31, 8'd3, 1, 0, 0, 0));
    vecs.push_back(mk(8'h32, 8'd0, 0, 0, 0, 1));
    vecs.push_back(mk(8'h33, 8'd0, 0, 0, 0, 1));
    vecs.push_back(mk(8'h34, 8'd0, 0, 1, 0, 1));
    vecs.push_back(mk(8'h35, 8'd0, 1, 1, 1, 1));
    vecs.push_back(mk(8'h41, 8'd0, 1, 0, 1, 1));
    vecs.push_back(mk(8'h42, 8'd5, 0, 0, 1, 0));
    vecs.push_back(mk(8'h43, 8'd0, 0, 1, 1, 1));
    for (int i = 0; i < 8; i++) begin
      vecs.push_back(mk(8'hA0 + 8'(i), 8'(i % 2), 0, 0, (i % 2) == 0, (i % 2) == 0));
    end
    vecs.push_back(mk(8'h51, 8'd0, 1, 0, 1, 1));
    vecs.push_back(mk(8'h52, 8'd2, 1, 0, 0, 0));
    vecs.push_back(mk(8'h53, 8'd0, 0, 1, 0, 1));

    // Reset state
    #12;
    chk("reset_in_ready", {31'd0, p_in_ready}, 0);
    chk("reset_out_valid", {31'd0, p_out_valid}, 0);
    chk("reset_out_data", {24'd0, p_out_data}, 0);
    chk("reset_drop_count", {16'd0, p_drop}, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    step();
    chk("ready_after_reset", {31'd0, p_in_ready}, 1);

    exp_p = 0;
    exp_b = 0;
    foreach (vecs[i]) begin
      beat(vecs[i].data, vecs[i].chan, vecs[i].sop, vecs[i].eop);
      chk($sformatf("v%0d_in_ready", i), {31'd0, p_in_ready & b_in_ready}, 1);
      step();
      exp_p += vecs[i].fwd_pkt ? 0 : 1;
      exp_b += vecs[i].fwd_beat ? 0 : 1;
      chk($sformatf("v%0d_pkt_valid", i), {31'd0, p_out_valid}, {31'd0, vecs[i].fwd_pkt});
      chk($sformatf("v%0d_beat_valid", i), {31'd0, b_out_valid}, {31'd0, vecs[i].fwd_beat});
      if (vecs[i].fwd_pkt) begin
        chk($sformatf("v%0d_pkt_data", i), {24'd0, p_out_data}, {24'd0, vecs[i].data});
        chk($sformatf("v%0d_pkt_chan", i), {31'd0, p_out_chan}, {31'd0, vecs[i].chan[0]});
        chk($sformatf("v%0d_pkt_sop", i), {31'd0, p_out_sop}, {31'd0, vecs[i].sop});
        chk($sformatf("v%0d_pkt_eop", i), {31'd0, p_out_eop}, {31'd0, vecs[i].eop});
      end
      if (vecs[i].fwd_beat) begin
        chk($sformatf("v%0d_beat_data", i), {24'd0, b_out_data}, {24'd0, vecs[i].data});
      end
      if (vecs[i].data == 8'h34) chk("pkt_drop_after_ch3_packet", {16'd0, p_drop}, 4);
    end
    idle();
    step();
    exp_s = (exp_b > 3) ? 3 : exp_b;
    chk("pkt_drop_total", {16'd0, p_drop}, exp_p);
    chk("beat_drop_total", {16'd0, b_drop}, exp_b);
    chk("sat_drop_total", {30'd0, s_drop}, exp_s);
    chk("drained_valid", {31'd0, p_out_valid}, 0);

    // Downstream stall for 3 cycles mid-stream
    cap_q.delete();
    beat(8'h21, 8'd0, 0, 0);
    step();
    out_ready = 1'b0;
    beat(8'h22, 8'd0, 0, 0);
    step();
    chk("stall_in_ready_after_2", {31'd0, p_in_ready}, 0);
    chk("stall_hold0", {24'd0, p_out_data}, 8'h21);
    beat(8'h23, 8'd0, 0, 0);
    step();
    chk("stall_hold1", {24'd0, p_out_data}, 8'h21);
    chk("stall_valid1", {31'd0, p_out_valid}, 1);
    step();
    chk("stall_hold2", {24'd0, p_out_data}, 8'h21);
    chk("stall_in_ready2", {31'd0, p_in_ready}, 0);
    out_ready = 1'b1;
    step();
    chk("release_skid_to_out", {24'd0, p_out_data}, 8'h22);
    chk("release_in_ready", {31'd0, p_in_ready}, 1);
    step();
    chk("release_third", {24'd0, p_out_data}, 8'h23);
    idle();
    step();
    step();
    chk("stall_cap_count", cap_q.size(), 3);
    if (cap_q.size() == 3) begin
      chk("stall_cap0", {24'd0, cap_q[0]}, 8'h21);
      chk("stall_cap1", {24'd0, cap_q[1]}, 8'h22);
      chk("stall_cap2", {24'd0, cap_q[2]}, 8'h23);
    end

    // Clear beats a concurrent drop, then saturation at 3 on the 2-bit counter
    drop_clr = 1'b1;
    beat(8'h70, 8'd1, 0, 0);
    step();
    drop_clr = 1'b0;
    chk("clr_pkt", {16'd0, p_drop}, 0);
    chk("clr_beat", {16'd0, b_drop}, 0);
    chk("clr_sat", {30'd0, s_drop}, 0);
    for (int i = 0; i < 5; i++) begin
      beat(8'h71 + 8'(i), 8'd1, 0, 0);
      step();
    end
    idle();
    step();
    chk("sat_after_5", {30'd0, s_drop}, 3);
    chk("beat_after_5", {16'd0, b_drop}, 5);
    chk("pkt_after_5", {16'd0, p_drop}, 5);

    // Reset mid-packet: buffered beat discarded, DROP state forgotten
    out_ready = 1'b0;
    beat(8'h60, 8'd0, 1, 0);
    step();
    beat(8'h61, 8'd3, 1, 0);
    step();
    idle();
    reset_n = 1'b0;
    #1;
    chk("midrst_in_ready", {31'd0, p_in_ready}, 0);
    chk("midrst_out_valid", {31'd0, p_out_valid}, 0);
    chk("midrst_drop", {16'd0, p_drop}, 0);
    step();
    reset_n = 1'b1;
    out_ready = 1'b1;
    step();
    chk("midrst_out_empty", {31'd0, p_out_valid}, 0);
    beat(8'h62, 8'd0, 0, 1);
    step();
    idle();
    chk("midrst_fresh_valid", {31'd0, p_out_valid}, 1);
    chk("midrst_fresh_data", {24'd0, p_out_data}, 8'h62);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
